// File: rtl/datapath_pack_fifo.sv
// Width-packing FIFO: gathers PACK_BEATS input beats into one wide entry and
// drains entries through a registered, rate-paced read port.
module datapath_pack_fifo #(
  parameter  int IN_WIDTH   = 64,
  parameter  int PACK_BEATS = 3,
  parameter  int DEPTH_LOG2 = 10,
  parameter  int DIV_WIDTH  = 8,
  localparam int OUT_WIDTH  = IN_WIDTH * PACK_BEATS,
  localparam int PIDX_W     = (PACK_BEATS > 1) ? $clog2(PACK_BEATS) : 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  wr,
  input  logic [IN_WIDTH-1:0]   data_in,
  input  logic                  rd,
  input  logic [DIV_WIDTH-1:0]  rate_div,
  input  logic [DEPTH_LOG2:0]   thresh,
  input  logic                  flush,
  input  logic                  clr_err,
  output logic [OUT_WIDTH-1:0]  data_out,
  output logic                  rd_valid,
  output logic [DEPTH_LOG2:0]   data_count,
  output logic [PIDX_W-1:0]     pack_idx,
  output logic                  full,
  output logic                  empty,
  output logic                  threshold,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int                DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_C = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [PIDX_W-1:0] LAST_IDX = PIDX_W'(PACK_BEATS - 1);

  logic [OUT_WIDTH-1:0]  mem [DEPTH];
  logic [DEPTH_LOG2-1:0] w_ptr;
  logic [DEPTH_LOG2-1:0] r_ptr;
  logic [DIV_WIDTH-1:0]  pace_cnt;
  logic [OUT_WIDTH-1:0]  commit_word;

  logic accept;
  logic commit;
  logic drop;
  logic tick;
  logic fire;
  logic starve;

  assign full      = (data_count == DEPTH_C);
  assign empty     = (data_count == '0);
  assign threshold = (data_count >= thresh);

  // Flush swallows any write or read request presented in the same cycle.
  assign accept = wr && !full && !flush;
  assign commit = accept && (pack_idx == LAST_IDX);
  assign drop   = wr && full && !flush;
  // A >= compare keeps pacing alive when rate_div is lowered below the count.
  assign tick   = (pace_cnt >= rate_div);
  assign fire   = rd && tick && !empty && !flush;
  assign starve = rd && tick && empty && !flush;

  // Stage p0: partial pack of beats 0..PACK_BEATS-2; the last beat goes
  // straight from data_in into memory on the commit edge.
  generate
    if (PACK_BEATS > 1) begin : g_stage
      logic [(PACK_BEATS-1)*IN_WIDTH-1:0] stage_p0;

      always_ff @(posedge clk) begin
        if (accept && !commit)
          stage_p0[int'(pack_idx)*IN_WIDTH +: IN_WIDTH] <= data_in;
      end

      assign commit_word = {data_in, stage_p0};
    end else begin : g_nostage
      assign commit_word = data_in;
    end
  endgenerate

  // Entry storage, left unreset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (commit)
      mem[w_ptr] <= commit_word;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_ptr      <= '0;
      r_ptr      <= '0;
      data_count <= '0;
      pack_idx   <= '0;
      pace_cnt   <= '0;
      rd_valid   <= 1'b0;
    end else if (flush) begin
      w_ptr      <= '0;
      r_ptr      <= '0;
      data_count <= '0;
      pack_idx   <= '0;
      pace_cnt   <= '0;
      rd_valid   <= 1'b0;
    end else begin
      pace_cnt <= tick ? '0 : pace_cnt + 1'b1;
      if (accept)
        pack_idx <= commit ? '0 : pack_idx + 1'b1;
      if (commit)
        w_ptr <= w_ptr + 1'b1;
      if (fire)
        r_ptr <= r_ptr + 1'b1;
      case ({commit, fire})
        2'b10:   data_count <= data_count + 1'b1;
        2'b01:   data_count <= data_count - 1'b1;
        default: data_count <= data_count;
      endcase
      rd_valid <= fire;
    end
  end

  // Stage p1: registered read port; holds its value between reads and flushes.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      data_out <= '0;
    else if (fire)
      data_out <= mem[r_ptr];
  end

  // Sticky error flags; a new event outranks a simultaneous clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (drop)
        overflow <= 1'b1;
      else if (clr_err)
        overflow <= 1'b0;
      if (starve)
        underflow <= 1'b1;
      else if (clr_err)
        underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_datapath_pack_fifo.sv
// Scoreboard bench for datapath_pack_fifo: packed entries are predicted as
// beats are driven and compared whenever rd_valid pulses.
module tb_datapath_pack_fifo;

  localparam int IW    = 64;
  localparam int PB    = 3;
  localparam int DL    = 10;
  localparam int DW    = 8;
  localparam int OW    = IW * PB;
  localparam int DEPTH = 1 << DL;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          wr = 1'b0;
  logic [IW-1:0] data_in = '0;
  logic          rd = 1'b0;
  logic [DW-1:0] rate_div = '0;
  logic [DL:0]   thresh = '0;
  logic          flush = 1'b0;
  logic          clr_err = 1'b0;
  logic [OW-1:0] data_out;
  logic          rd_valid;
  logic [DL:0]   data_count;
  logic [1:0]    pack_idx;
  logic          full;
  logic          empty;
  logic          threshold;
  logic          overflow;
  logic          underflow;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [OW-1:0] exp_q[$];
  logic [OW-1:0] sb_exp;
  logic [OW-1:0] last_exp = '0;
  logic [IW-1:0] part[PB];
  int            part_n = 0;
  int            rv_cyc_q[$];

  datapath_pack_fifo #(
    .IN_WIDTH  (IW),
    .PACK_BEATS(PB),
    .DEPTH_LOG2(DL),
    .DIV_WIDTH (DW)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .wr        (wr),
    .data_in   (data_in),
    .rd        (rd),
    .rate_div  (rate_div),
    .thresh    (thresh),
    .flush     (flush),
    .clr_err   (clr_err),
    .data_out  (data_out),
    .rd_valid  (rd_valid),
    .data_count(data_count),
    .pack_idx  (pack_idx),
    .full      (full),
    .empty     (empty),
    .threshold (threshold),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every read-data pulse must match the oldest predicted entry.
  always @(negedge clk) begin
    if (rstn && rd_valid) begin
      rv_cyc_q.push_back(cyc);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_data: rd_valid with no expected entry, data_out=%h", data_out);
      end else begin
        sb_exp = exp_q.pop_front();
        last_exp = sb_exp;
        if (data_out !== sb_exp) begin
          errors++;
          $display("FAIL sb_data: got %h expected %h", data_out, sb_exp);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    exp_q.delete();
    part_n = 0;
  endtask

  task automatic put_beat(input logic [IW-1:0] d);
    logic [OW-1:0] w;
    wr = 1'b1;
    data_in = d;
    part[part_n] = d;
    part_n++;
    if (part_n == PB) begin
      for (int i = 0; i < PB; i++) w[i*IW +: IW] = part[i];
      exp_q.push_back(w);
      part_n = 0;
    end
    step();
    wr = 1'b0;
  endtask

  task automatic put_entry();
    for (int i = 0; i < PB; i++) put_beat({$urandom, $urandom});
  endtask

  task automatic drain();
    bit done = 0;
    rd = 1'b1;
    for (int i = 0; i < 4 * DEPTH; i++) begin
      step();
      if (empty) begin
        done = 1;
        break;
      end
    end
    rd = 1'b0;
    step();
    checks++;
    if (!done || exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: done=%0d entries_left=%0d required done=1 left=0", done, exp_q.size());
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (data_count !== '0 || pack_idx !== '0 || full !== 1'b0 || empty !== 1'b1 ||
        rd_valid !== 1'b0 || data_out !== '0 || overflow !== 1'b0 || underflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: cnt=%0d idx=%0d full=%b empty=%b rv=%b ovf=%b unf=%b",
               data_count, pack_idx, full, empty, rd_valid, overflow, underflow);
    end
    checks++;
    if (threshold !== 1'b1) begin
      errors++;
      $display("FAIL reset_thresh0: threshold=%b required 1", threshold);
    end
    thresh = 5;
    #1;
    checks++;
    if (threshold !== 1'b0) begin
      errors++;
      $display("FAIL reset_thresh5: threshold=%b required 0", threshold);
    end
    thresh = 0;
    @(negedge clk);
    rstn = 1'b1;
    step();
  endtask

  task automatic test_basic();
    logic [IW-1:0] a = 64'hA0A1_A2A3_A4A5_A6A7;
    logic [IW-1:0] b = 64'hB0B1_B2B3_B4B5_B6B7;
    logic [IW-1:0] c = 64'hC0C1_C2C3_C4C5_C6C7;
    logic [OW-1:0] cba = {c, b, a};
    rate_div = 0;
    put_beat(a);
    checks++;
    if (pack_idx !== 2'd1) begin
      errors++;
      $display("FAIL basic_idx1: pack_idx=%0d required 1", pack_idx);
    end
    put_beat(b);
    checks++;
    if (pack_idx !== 2'd2 || data_count !== '0) begin
      errors++;
      $display("FAIL basic_idx2: pack_idx=%0d cnt=%0d required 2/0", pack_idx, data_count);
    end
    put_beat(c);
    checks++;
    if (pack_idx !== 2'd0 || data_count !== 11'd1 || empty !== 1'b0) begin
      errors++;
      $display("FAIL basic_commit: pack_idx=%0d cnt=%0d empty=%b required 0/1/0",
               pack_idx, data_count, empty);
    end
    rd = 1'b1;
    step();
    rd = 1'b0;
    checks++;
    if (rd_valid !== 1'b1 || data_out !== cba || data_count !== '0) begin
      errors++;
      $display("FAIL basic_read: rv=%b cnt=%0d data=%h required 1/0/%h",
               rd_valid, data_count, data_out, cba);
    end
    step();
    checks++;
    if (rd_valid !== 1'b0 || data_out !== cba) begin
      errors++;
      $display("FAIL basic_pulse: rv=%b data=%h required 0/%h", rd_valid, data_out, cba);
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < PB * DEPTH; i++) put_beat({$urandom, $urandom});
    checks++;
    if (full !== 1'b1 || data_count !== 11'(DEPTH)) begin
      errors++;
      $display("FAIL full_flag: full=%b cnt=%0d required 1/%0d", full, data_count, DEPTH);
    end
    wr = 1'b1;
    data_in = 64'hDEAD_BEEF_DEAD_BEEF;
    step();
    wr = 1'b0;
    checks++;
    if (overflow !== 1'b1 || data_count !== 11'(DEPTH) || pack_idx !== 2'd0) begin
      errors++;
      $display("FAIL full_overflow: ovf=%b cnt=%0d idx=%0d required 1/%0d/0",
               overflow, data_count, pack_idx, DEPTH);
    end
    rd = 1'b1;
    step();
    rd = 1'b0;
    checks++;
    if (full !== 1'b0 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL full_read: full=%b ovf=%b required 0/1", full, overflow);
    end
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL full_clr: ovf=%b required 0", overflow);
    end
    drain();
    checks++;
    if (underflow !== 1'b0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL full_drained: unf=%b empty=%b required 0/1", underflow, empty);
    end
  endtask

  task automatic test_pacing();
    bit found = 0;
    int ucyc = 0;
    rate_div = 29;
    for (int i = 0; i < 5; i++) put_entry();
    rv_cyc_q.delete();
    rd = 1'b1;
    for (int i = 0; i < 400 && rv_cyc_q.size() < 5; i++) step();
    checks++;
    if (rv_cyc_q.size() != 5) begin
      errors++;
      $display("FAIL pace_pulses: got %0d pulses required 5", rv_cyc_q.size());
    end else begin
      for (int i = 1; i < 5; i++) begin
        checks++;
        if (rv_cyc_q[i] - rv_cyc_q[i-1] != 30) begin
          errors++;
          $display("FAIL pace_gap%0d: gap=%0d required 30", i, rv_cyc_q[i] - rv_cyc_q[i-1]);
        end
      end
      checks++;
      if (empty !== 1'b1) begin
        errors++;
        $display("FAIL pace_empty: empty=%b required 1", empty);
      end
      for (int i = 0; i < 60; i++) begin
        step();
        if (underflow) begin
          found = 1;
          ucyc = cyc;
          break;
        end
      end
      checks++;
      if (!found || ucyc - rv_cyc_q[4] != 30) begin
        errors++;
        $display("FAIL pace_underflow: seen=%0d delay=%0d required 1/30", found, ucyc - rv_cyc_q[4]);
      end
    end
    rd = 1'b0;
    step();
    checks++;
    if (rv_cyc_q.size() != 5) begin
      errors++;
      $display("FAIL pace_extra: pulses=%0d required 5", rv_cyc_q.size());
    end
    rate_div = 0;
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    checks++;
    if (underflow !== 1'b0) begin
      errors++;
      $display("FAIL pace_clr: unf=%b required 0", underflow);
    end
  endtask

  task automatic test_threshold();
    rate_div = 0;
    thresh = 4;
    for (int i = 0; i < 3; i++) put_entry();
    checks++;
    if (threshold !== 1'b0 || data_count !== 11'd3) begin
      errors++;
      $display("FAIL thr_below: thr=%b cnt=%0d required 0/3", threshold, data_count);
    end
    put_entry();
    checks++;
    if (threshold !== 1'b1) begin
      errors++;
      $display("FAIL thr_rise: thr=%b required 1", threshold);
    end
    rd = 1'b1;
    step();
    rd = 1'b0;
    checks++;
    if (threshold !== 1'b0) begin
      errors++;
      $display("FAIL thr_fall: thr=%b required 0", threshold);
    end
    drain();
    thresh = 0;
  endtask

  task automatic test_back_to_back();
    rate_div = 0;
    put_entry();
    put_entry();
    for (int k = 0; k < 4; k++) begin
      put_beat({$urandom, $urandom});
      put_beat({$urandom, $urandom});
      rd = 1'b1;
      put_beat({$urandom, $urandom});
      rd = 1'b0;
      checks++;
      if (data_count !== 11'd2) begin
        errors++;
        $display("FAIL b2b_count%0d: cnt=%0d required 2", k, data_count);
      end
    end
    drain();
    checks++;
    if (underflow !== 1'b0) begin
      errors++;
      $display("FAIL b2b_unf: unf=%b required 0", underflow);
    end
  endtask

  task automatic test_flush();
    logic [IW-1:0] x = 64'h1111_2222_3333_4444;
    logic [IW-1:0] y = 64'h5555_6666_7777_8888;
    logic [IW-1:0] z = 64'h9999_AAAA_BBBB_CCCC;
    logic [OW-1:0] zyx = {z, y, x};
    rate_div = 0;
    put_entry();
    put_beat({$urandom, $urandom});
    put_beat({$urandom, $urandom});
    checks++;
    if (pack_idx !== 2'd2 || data_count !== 11'd1) begin
      errors++;
      $display("FAIL flush_pre: idx=%0d cnt=%0d required 2/1", pack_idx, data_count);
    end
    flush = 1'b1;
    wr = 1'b1;
    data_in = 64'hBAD0_BAD0_BAD0_BAD0;
    step();
    flush = 1'b0;
    wr = 1'b0;
    model_clear();
    checks++;
    if (pack_idx !== 2'd0 || data_count !== '0 || empty !== 1'b1 || data_out !== last_exp) begin
      errors++;
      $display("FAIL flush_state: idx=%0d cnt=%0d empty=%b data=%h required 0/0/1/%h",
               pack_idx, data_count, empty, data_out, last_exp);
    end
    put_beat(x);
    put_beat(y);
    put_beat(z);
    rd = 1'b1;
    step();
    rd = 1'b0;
    checks++;
    if (rd_valid !== 1'b1 || data_out !== zyx) begin
      errors++;
      $display("FAIL flush_fresh: rv=%b data=%h required 1/%h", rd_valid, data_out, zyx);
    end
    step();
  endtask

  task automatic test_async_reset();
    logic [IW-1:0] d = 64'h0D0D_0D0D_0D0D_0D0D;
    logic [IW-1:0] e = 64'h0E0E_0E0E_0E0E_0E0E;
    logic [IW-1:0] f = 64'h0F0F_0F0F_0F0F_0F0F;
    logic [OW-1:0] fed = {f, e, d};
    rate_div = 0;
    put_entry();
    put_entry();
    put_beat({$urandom, $urandom});
    rd = 1'b1;
    step();
    rd = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if (rd_valid !== 1'b0 || data_out !== '0 || data_count !== '0 || pack_idx !== '0 ||
        empty !== 1'b1 || full !== 1'b0) begin
      errors++;
      $display("FAIL areset_state: rv=%b data=%h cnt=%0d idx=%0d empty=%b full=%b",
               rd_valid, data_out, data_count, pack_idx, empty, full);
    end
    model_clear();
    #3;
    rstn = 1'b1;
    step();
    put_beat(d);
    put_beat(e);
    put_beat(f);
    rd = 1'b1;
    step();
    rd = 1'b0;
    checks++;
    if (rd_valid !== 1'b1 || data_out !== fed || data_count !== '0) begin
      errors++;
      $display("FAIL areset_entry0: rv=%b cnt=%0d data=%h required 1/0/%h",
               rd_valid, data_count, data_out, fed);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_pacing();
    test_threshold();
    test_back_to_back();
    test_flush();
    test_async_reset();
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
